reg_write_arbiter: RTL and testbench
====================================

Name: reg_write_arbiter

Overview:
- Round-robin arbiter sharing one registered WIDTH-bit write port among N_REQ requesters.
- Each requester presents valid/data. The arbiter accepts one word per cycle into a single-entry output register, then presents it downstream with a valid/ready handshake.
- Sits in front of the sequential datapath registers so several producers can load one `always_ff` register without conflicts.

Parameters:
- N_REQ, 4, number of requesters; power of two, 2..8.
- WIDTH, 8, data width of each request and of the output word.
- IDX_W, $clog2(N_REQ), width of the requester index.

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  N_REQ  bit i: requester i has a word.
- req_data  input  N_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  one-hot or zero; bit i: requester i word accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  held word.
- out_idx  output  IDX_W  index of the requester that supplied out_data.
- out_ready  input  1  downstream consumes the word when out_valid && out_ready.

Behaviour:
- One clock; reset is synchronous and active-low on rst_n, sampled at posedge clk.
- Reset values:
  - out_valid=0, out_data=0, out_idx=0.
  - Priority pointer ptr=0.
  - While rst_n=0, req_ready=0.
- State:
  - Output slot: EMPTY when out_valid=0, FULL when out_valid=1.
  - Priority pointer ptr is IDX_W bits.
- load = (!out_valid || out_ready) && rst_n && (|req_valid).
- Winner selection:
  - Combinational scan of indices ptr, ptr+1, …, ptr+N_REQ-1, all mod N_REQ.
  - Winner w is the first index with req_valid set.
- req_ready[w] = load. Other bits are 0. Purely combinational, same cycle as req_valid.
- On a load cycle, at the next posedge:
  - out_data <= req_data[w], out_idx <= w, out_valid <= 1.
  - ptr <= (w+1) mod N_REQ.
- Downstream drain: if out_valid && out_ready && !(|req_valid), then out_valid <= 0. out_data and out_idx keep their values.
- FULL && !out_ready: out_valid, out_data and out_idx are held stable. req_ready=0, so there is no backpressure violation.
- FULL && out_ready && a request present: the drain and the load happen in the same cycle. This gives full throughput of one word per cycle.
- Latency: a word accepted at cycle N appears on out_* at cycle N+1. Minimum stall is zero cycles.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,2,3,0,…
  - No requester waits more than N_REQ-1 grants after asserting valid.
- ptr advances only on an actual grant. Idle cycles and stalls do not move it.
- A requester dropping req_valid without a handshake is allowed. It is simply not selected; no state is kept for it.
- Reset mid-operation: a pending output word is discarded (out_valid=0 next cycle), ptr returns to 0, and no req_ready is asserted during the reset cycle.
- Index arithmetic is modulo N_REQ and wraps naturally in IDX_W bits.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 → req_ready=0 throughout; out_valid=0, out_data=0, out_idx=0 after the first posedge.
- Single request: req_valid=4'b0100, req_data[2]=8'hA5, out_ready=1 →
  - req_ready=4'b0100 in the same cycle.
  - Next cycle out_valid=1, out_data=8'hA5, out_idx=2.
  - ptr=3.
- Round-robin: all four valid with data 8'h10,8'h11,8'h12,8'h13, out_ready=1 for 6 cycles → out_idx sequence 0,1,2,3,0,1 with matching data; one word per cycle.
- Backpressure: FULL with out_data=8'h3C and out_ready=0 for 3 cycles while requester 1 is valid →
  - out_* stable and req_ready=0 during the stall.
  - When out_ready rises: same-cycle drain and load; next cycle out_idx=1.
- Pointer wrap: after a grant to requester 3, requesters 0 and 3 both valid → requester 0 is granted; ptr=1.
- Mid-operation reset: out_valid=1 and out_ready=0, then rst_n=0 for one cycle → out_valid=0 next cycle; after release with requesters 1 and 2 valid, requester 1 is granted first (ptr=0).

Source files
------------

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// -----------------
// Round-robin arbiter that funnels up to N_REQ producers into one registered
// WIDTH-bit write port. One word is accepted per cycle into a single-entry
// output register, which is then offered downstream with valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  per-requester "has a word" flags
//   req_data   packed requester words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot (or zero) acceptance strobe, combinational
//   out_valid  output register holds a word
//   out_data   held word
//   out_idx    index of the requester that supplied out_data
//   out_ready  downstream consumes the word when out_valid && out_ready
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_idx,
  input  logic                   out_ready
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             any_req;
  logic             load;

  assign any_req = |req_valid;

  // The slot can take a new word when it is empty or is being drained this
  // same cycle; that is what gives one word per cycle of throughput.
  assign load = (!out_valid || out_ready) && rst_n && any_req;

  // Scan from the farthest rotated position back toward ptr so that the last
  // hit written is the closest one at or after ptr. N_REQ is a power of two,
  // so the IDX_W-bit addition wraps exactly modulo N_REQ.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req_valid[cand]) begin
        win = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (load) begin
      req_ready[win] = 1'b1;
    end
  end

  // Output register and priority pointer. The pointer only moves on an
  // actual grant; on a drain without a new word, data and index are kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= req_data[win*WIDTH +: WIDTH];
      out_idx   <= win;
      ptr       <= win + IDX_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
// --------------------
// Self-checking bench for reg_write_arbiter: directed scenarios followed by a
// randomized run, compared against a behavioural model of the arbiter.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_idx;
  logic           out_ready;

  int vectors;
  int miscompares;

  // Behavioural model state
  int             m_ptr;
  logic           m_valid;
  logic [W-1:0]   m_data;
  logic [IW-1:0]  m_idx;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First valid requester at or after the model pointer, modulo N; -1 if none
  function automatic int grant_idx();
    for (int off = 0; off < N; off++) begin
      if (req_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = grant_idx();
    if (rst_n && (!m_valid || out_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // Advance the model by one clock using the currently driven inputs, then
  // step the clock and settle just past the edge.
  task automatic tick();
    int w;
    w = grant_idx();
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_idx   = '0;
      m_ptr   = 0;
    end else if ((!m_valid || out_ready) && w >= 0) begin
      m_valid = 1'b1;
      m_data  = req_data[w*W +: W];
      m_idx   = IW'(w);
      m_ptr   = (w + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready);
      end
      tick();
      vectors++;
      if ({out_valid, out_data, out_idx} !== {1'b0, 8'h00, 2'd0}) begin
        miscompares++;
        $display("[TB] FAIL reset_out: got v=%b d=%h i=%0d expected v=0 d=00 i=0",
                 out_valid, out_data, out_idx);
      end
    end
  endtask

  task automatic test_single();
    rst_n     = 1'b1;
    req_valid = 4'b0100;
    req_data  = '0;
    req_data[2*W +: W] = 8'hA5;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL single_ready: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    vectors++;
    if ({out_valid, out_data, out_idx} !== {1'b1, 8'hA5, 2'd2}) begin
      miscompares++;
      $display("[TB] FAIL single_out: got v=%b d=%h i=%0d expected v=1 d=a5 i=2",
               out_valid, out_data, out_idx);
    end
    // ptr is now 3: with 0 and 3 both valid, 3 must win
    req_valid = 4'b1001;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL single_ptr: got %b expected 1000", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'(1 << exp_seq[c])) begin
        miscompares++;
        $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, 4'(1 << exp_seq[c]));
      end
      tick();
      vectors++;
      if ({out_valid, out_data, out_idx} !== {1'b1, 8'(8'h10 + exp_seq[c]), 2'(exp_seq[c])}) begin
        miscompares++;
        $display("[TB] FAIL rr_out[%0d]: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d",
                 c, out_valid, out_data, out_idx, 8'(8'h10 + exp_seq[c]), exp_seq[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    req_data  = '0;
    req_data[0 +: W] = 8'h3C;
    out_ready = 1'b1;
    tick();
    req_valid = 4'b0010;
    req_data[W +: W] = 8'h77;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL bp_ready[%0d]: got %b expected 0000", c, req_ready);
      end
      tick();
      vectors++;
      if ({out_valid, out_data, out_idx} !== {1'b1, 8'h3C, 2'd0}) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b d=%h i=%0d expected v=1 d=3c i=0",
                 c, out_valid, out_data, out_idx);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL bp_release_ready: got %b expected 0010", req_ready);
    end
    tick();
    vectors++;
    if ({out_valid, out_data, out_idx} !== {1'b1, 8'h77, 2'd1}) begin
      miscompares++;
      $display("[TB] FAIL bp_release_out: got v=%b d=%h i=%0d expected v=1 d=77 i=1",
               out_valid, out_data, out_idx);
    end
  endtask

  task automatic test_pointer_wrap();
    req_valid = 4'b1000;
    req_data  = 32'hD3C2B1A0;
    out_ready = 1'b1;
    tick();
    req_valid = 4'b1001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL wrap_ready: got %b expected 0001", req_ready);
    end
    tick();
    vectors++;
    if ({out_valid, out_data, out_idx} !== {1'b1, 8'hA0, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_out: got v=%b d=%h i=%0d expected v=1 d=a0 i=0",
               out_valid, out_data, out_idx);
    end
    // ptr should now be 1
    req_valid = 4'b0011;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL wrap_ptr: got %b expected 0010", req_ready);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    req_valid = 4'b0001;
    req_data  = 32'h44332211;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL midrst_ready: got %b expected 0000", req_ready);
    end
    tick();
    vectors++;
    if ({out_valid, out_data, out_idx} !== {1'b0, 8'h00, 2'd0}) begin
      miscompares++;
      $display("[TB] FAIL midrst_out: got v=%b d=%h i=%0d expected v=0 d=00 i=0",
               out_valid, out_data, out_idx);
    end
    rst_n     = 1'b1;
    req_valid = 4'b0110;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL midrst_grant: got %b expected 0010", req_ready);
    end
    tick();
    vectors++;
    if ({out_valid, out_data, out_idx} !== {1'b1, 8'h22, 2'd1}) begin
      miscompares++;
      $display("[TB] FAIL midrst_out2: got v=%b d=%h i=%0d expected v=1 d=22 i=1",
               out_valid, out_data, out_idx);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 24) != 0);
      req_valid = N'($urandom_range(0, 15));
      req_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_ready();
      vectors++;
      if (req_ready !== er) begin
        miscompares++;
        $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, er);
      end
      tick();
      vectors++;
      if ({out_valid, out_data, out_idx} !== {m_valid, m_data, m_idx}) begin
        miscompares++;
        $display("[TB] FAIL rand_out[%0d]: got v=%b d=%h i=%0d expected v=%b d=%h i=%0d",
                 c, out_valid, out_data, out_idx, m_valid, m_data, m_idx);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_ptr       = 0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_idx       = '0;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    out_ready   = 1'b0;
    $display("[TB] starting reg_write_arbiter bench");
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_wrap();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
